// File: rtl/cic_comp_fir.sv
// Serial-MAC compensation FIR for the CIC decimator output: one shared multiplier,
// optional decimate-by-2, drops (and flags) samples that arrive while busy.
module cic_comp_fir #(
   parameter int INP_DW    = 32,
   parameter int OUT_DW    = 32,
   parameter int COEF_DW   = 18,
   parameter int NUM_TAPS  = 16,
   parameter int DECIM     = 2,
   parameter int OUT_SHIFT = COEF_DW - 1,
   parameter logic [COEF_DW*NUM_TAPS-1:0] COEFS = '0
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [INP_DW-1:0] s_axis_in_tdata,
   input  logic              s_axis_in_tvalid,
   output logic              s_axis_in_tready,
   output logic [OUT_DW-1:0] m_axis_out_tdata,
   output logic              m_axis_out_tvalid,
   output logic              overrun
);

   localparam int ACC_DW  = INP_DW + COEF_DW + $clog2(NUM_TAPS);
   localparam int PROD_DW = INP_DW + COEF_DW;
   localparam int PW      = $clog2(NUM_TAPS);
   localparam int RW      = (ACC_DW + 1 > OUT_DW + 1) ? ACC_DW + 1 : OUT_DW + 1;

   localparam logic [PW-1:0]        LAST_IDX   = PW'(NUM_TAPS - 1);
   localparam logic [0:0]           LAST_PHASE = 1'(DECIM - 1);
   localparam logic signed [RW-1:0] RND  = (RW'(1) << OUT_SHIFT) >> 1;
   localparam logic signed [RW-1:0] OMAX = {{(RW-OUT_DW+1){1'b0}}, {(OUT_DW-1){1'b1}}};
   localparam logic signed [RW-1:0] OMIN = {{(RW-OUT_DW+1){1'b1}}, {(OUT_DW-1){1'b0}}};

   typedef enum logic [1:0] {IDLE, MAC, ROUND} state_t;

   state_t                     state;
   logic signed [INP_DW-1:0]   dline [NUM_TAPS];
   logic [PW-1:0]              wr_ptr;
   logic [PW-1:0]              rd_ptr;
   logic [PW-1:0]              tap;
   logic [0:0]                 phase;
   logic signed [ACC_DW-1:0]   acc;
   logic signed [COEF_DW-1:0]  coef;
   logic signed [PROD_DW-1:0]  prod;
   logic signed [RW-1:0]       rnd;
   logic signed [RW-1:0]       shifted;
   logic signed [OUT_DW-1:0]   sat;
   logic                       accept;

   assign accept = s_axis_in_tvalid && s_axis_in_tready;

   always_comb begin
      coef    = COEFS[COEF_DW*int'(tap) +: COEF_DW];
      prod    = dline[rd_ptr] * coef;
      rnd     = RW'(acc) + RND;
      shifted = rnd >>> OUT_SHIFT;
      if (shifted > OMAX)
         sat = OMAX[OUT_DW-1:0];
      else if (shifted < OMIN)
         sat = OMIN[OUT_DW-1:0];
      else
         sat = shifted[OUT_DW-1:0];
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state             <= IDLE;
         s_axis_in_tready  <= 1'b1;
         m_axis_out_tvalid <= 1'b0;
         m_axis_out_tdata  <= '0;
         overrun           <= 1'b0;
         phase             <= '0;
         wr_ptr            <= '0;
         rd_ptr            <= '0;
         tap               <= '0;
         acc               <= '0;
         for (int unsigned i = 0; i < NUM_TAPS; i++)
            dline[i] <= '0;
      end else begin
         m_axis_out_tvalid <= 1'b0;
         if (s_axis_in_tvalid && !s_axis_in_tready)
            overrun <= 1'b1;
         case (state)
            IDLE: begin
               if (accept) begin
                  dline[wr_ptr] <= s_axis_in_tdata;
                  wr_ptr        <= (wr_ptr == LAST_IDX) ? '0 : wr_ptr + 1'b1;
                  phase         <= (phase == LAST_PHASE) ? '0 : phase + 1'b1;
                  if (phase == LAST_PHASE) begin
                     // the MAC walks backwards in time from the sample just written
                     state            <= MAC;
                     s_axis_in_tready <= 1'b0;
                     rd_ptr           <= wr_ptr;
                     tap              <= '0;
                     acc              <= '0;
                  end
               end
            end
            MAC: begin
               acc    <= acc + ACC_DW'(prod);
               rd_ptr <= (rd_ptr == '0) ? LAST_IDX : rd_ptr - 1'b1;
               tap    <= tap + 1'b1;
               if (tap == LAST_IDX)
                  state <= ROUND;
            end
            ROUND: begin
               m_axis_out_tdata  <= sat;
               m_axis_out_tvalid <= 1'b1;
               s_axis_in_tready  <= 1'b1;
               state             <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
